// File: rtl/pf_lanectrl_pause_ctrl_if.sv
// rtl/pf_lanectrl_pause_ctrl_if.sv - update-request / pause handshake bundle for the lane pause controller
//
// Signals:
//   UPDATE_REQ       requester -> controller, level request for one delay-code update
//   HS_IO_CLK_PAUSE  controller -> pause synchroniser, raw pause request
//   DELAY_LOAD       controller -> delay line, one-cycle load strobe
//   UPDATE_ACK       controller -> requester, one-cycle completion pulse
//   BUSY             controller -> requester, sequence in progress
//   UPDATE_COUNT     controller -> status, completed-update counter (wraps)
interface pf_lanectrl_pause_ctrl_if;
    logic       UPDATE_REQ;
    logic       HS_IO_CLK_PAUSE;
    logic       DELAY_LOAD;
    logic       UPDATE_ACK;
    logic       BUSY;
    logic [7:0] UPDATE_COUNT;

    modport master (
        output UPDATE_REQ,
        input  HS_IO_CLK_PAUSE,
        input  DELAY_LOAD,
        input  UPDATE_ACK,
        input  BUSY,
        input  UPDATE_COUNT
    );

    modport slave (
        input  UPDATE_REQ,
        output HS_IO_CLK_PAUSE,
        output DELAY_LOAD,
        output UPDATE_ACK,
        output BUSY,
        output UPDATE_COUNT
    );
endinterface

// File: rtl/pf_lanectrl_pause_ctrl.sv
// rtl/pf_lanectrl_pause_ctrl.sv - brackets each delay-code update with a pause window and enforces a gap
//
// Ports:
//   CLK    fabric clock, rising edge
//   RESET  asynchronous, active-high reset
//   bus    pf_lanectrl_pause_ctrl_if.slave: UPDATE_REQ in; HS_IO_CLK_PAUSE, DELAY_LOAD,
//          UPDATE_ACK, BUSY, UPDATE_COUNT out (all flop outputs)
module pf_lanectrl_pause_ctrl #(
    parameter int PRE_CYCLES  = 2,
    parameter int POST_CYCLES = 3,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    pf_lanectrl_pause_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_LOAD = 3'd2,
        S_POST = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [3:0] PRE_RELOAD  = 4'(PRE_CYCLES - 1);
    localparam logic [3:0] POST_RELOAD = 4'(POST_CYCLES - 1);
    localparam logic [3:0] GAP_RELOAD  = 4'(GAP_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;

    logic       r_pause;
    logic       r_load;
    logic       r_ack;
    logic       r_busy;
    logic [7:0] r_count;

    // The edge that moves POST -> GAP completes an update: it fires the ack and bumps the count.
    logic       w_enter_gap;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.UPDATE_REQ) begin
                    w_next_state = S_PRE;
                    w_next_cnt   = PRE_RELOAD;
                end
            end
            S_PRE: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_LOAD: begin
                w_next_state = S_POST;
                w_next_cnt   = POST_RELOAD;
            end
            S_POST: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_GAP;
                    w_next_cnt   = GAP_RELOAD;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    assign w_enter_gap = (w_next_state == S_GAP) && (r_state != S_GAP);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    // while still being plain flop outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pause <= 1'b0;
            r_load  <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= 8'd0;
        end else begin
            r_pause <= (w_next_state == S_PRE) || (w_next_state == S_LOAD) || (w_next_state == S_POST);
            r_load  <= (w_next_state == S_LOAD);
            r_ack   <= w_enter_gap;
            r_busy  <= (w_next_state != S_IDLE);
            if (w_enter_gap) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign bus.HS_IO_CLK_PAUSE = r_pause;
    assign bus.DELAY_LOAD      = r_load;
    assign bus.UPDATE_ACK      = r_ack;
    assign bus.BUSY            = r_busy;
    assign bus.UPDATE_COUNT    = r_count;

endmodule

// File: doc/pf_lanectrl_pause_ctrl.md
# pf_lanectrl_pause_ctrl

Generates the raw `HS_IO_CLK_PAUSE` request that feeds the lane-controller pause synchroniser. It brackets each delay-line code update with a clean, parameterised pause window: pause rises first, then a single-cycle `DELAY_LOAD` strobe, then pause is held for a settling period. A minimum gap is enforced before the next update. The block sits between the training/delay-update logic and the pause synchroniser, on the same fabric clock.

## Interface
- `PRE_CYCLES`, default 2: cycles pause is high before `DELAY_LOAD`. Legal range 1..15.
- `POST_CYCLES`, default 3: cycles pause stays high after `DELAY_LOAD`. Legal range 1..15.
- `GAP_CYCLES`, default 4: minimum idle cycles after pause drops before the next request is accepted. Legal range 1..15.
- `CLK`  input  1  fabric clock; the single clock of the block. All logic is sampled on the rising edge.
- `RESET`  input  1  asynchronous, active-high reset.
- `UPDATE_REQ`  input  1  level request for one delay-code update.
- `HS_IO_CLK_PAUSE`  output  1  registered pause request to the pause synchroniser.
- `DELAY_LOAD`  output  1  one-cycle strobe that loads the new delay code.
- `UPDATE_ACK`  output  1  one-cycle pulse; the update is complete.
- `BUSY`  output  1  high whenever the state is not IDLE.
- `UPDATE_COUNT`  output  8  count of completed updates; wraps.

## Operation
- Clock and reset: one clock (`CLK`); reset (`RESET`) is asynchronous and active-high.
- FSM states: IDLE, PRE, LOAD, POST, GAP. A 4-bit down-counter times PRE, POST and GAP.
- IDLE:
  - If `UPDATE_REQ`=1 at an edge, go to PRE and load the counter with `PRE_CYCLES`-1.
  - Otherwise stay in IDLE.
- PRE:
  - Decrement the counter each cycle.
  - When the counter is 0, go to LOAD.
- LOAD: lasts exactly one cycle, then go to POST and load the counter with `POST_CYCLES`-1.
- POST: decrement the counter; when it is 0, go to GAP and load the counter with `GAP_CYCLES`-1.
- GAP: decrement the counter; when it is 0, go to IDLE.
- All outputs are registered and decoded from the next state, so there is no combinational path from `UPDATE_REQ` to any output.
- `HS_IO_CLK_PAUSE` = 1 in PRE, LOAD and POST.
- `DELAY_LOAD` = 1 only in LOAD.
- `UPDATE_ACK` = 1 only in the first GAP cycle.
- `UPDATE_COUNT` increments by 1 on the edge that enters GAP. It wraps from 255 to 0.
- `UPDATE_REQ` handshake:
  - `UPDATE_REQ` is sampled only in IDLE.
  - The requester must drop `UPDATE_REQ` by the cycle after `UPDATE_ACK`.
  - If `UPDATE_REQ` is still high when the FSM returns to IDLE, a new sequence starts. This is legal back-to-back operation.
  - `UPDATE_REQ` toggling outside IDLE is ignored; it is neither queued nor counted.
- Reset, including mid-sequence:
  - The state goes to IDLE and the counter is cleared.
  - All outputs go to 0 immediately (asynchronously), including `UPDATE_COUNT`=0.
  - An in-flight update is dropped without `UPDATE_ACK`.
- Reset release: the first possible acceptance is on the first `CLK` edge after `RESET` falls.

## Timing
- `UPDATE_REQ` is sampled high at edge k.
- `HS_IO_CLK_PAUSE` and `BUSY` rise after edge k.
- `DELAY_LOAD` is high from edge k+`PRE_CYCLES` to edge k+`PRE_CYCLES`+1.
- `HS_IO_CLK_PAUSE` falls after edge k+`PRE_CYCLES`+1+`POST_CYCLES`. Its width is `PRE_CYCLES`+1+`POST_CYCLES` cycles, which is never shorter than 3. Because of this, the downstream pause-extension logic never needs to stretch it.
- `UPDATE_ACK` is high for the one cycle after pause falls.
- `BUSY` falls after edge k+`PRE_CYCLES`+1+`POST_CYCLES`+`GAP_CYCLES`.
- Back-to-back requests are spaced `PRE_CYCLES`+1+`POST_CYCLES`+`GAP_CYCLES`+1 cycles apart (request edge to request edge).
- Outputs are glitch-free: every output is a flop Q.
- Parameter values outside 1..15 are illegal. The bench checks them with an elaboration-time assertion.

## Test plan
- Reset, then one request with defaults (PRE=2, POST=3, GAP=4). Required response:
  - pause high for 6 cycles;
  - `DELAY_LOAD` in pause cycle 3;
  - `UPDATE_ACK` in the cycle after pause;
  - `BUSY` high for 10 cycles;
  - `UPDATE_COUNT`=1.
- `UPDATE_REQ` held high continuously for 3 sequences. Required response:
  - 3 `UPDATE_ACK` pulses, 11 cycles apart;
  - pause low for exactly 5 cycles between windows;
  - `UPDATE_COUNT`=3.
- `UPDATE_REQ` pulsed during POST and during GAP, low otherwise. Required response: no extra sequence, `UPDATE_COUNT` unchanged.
- `RESET` asserted during LOAD. Required response:
  - all outputs 0 immediately;
  - no `UPDATE_ACK`;
  - `UPDATE_COUNT`=0;
  - after release, a new request yields the normal 6-cycle window.
- 256 sequences. Required response: `UPDATE_COUNT` wraps to 0, and `UPDATE_ACK` count = 256.
- PRE=1, POST=1, GAP=1. Required response:
  - pause width 3;
  - `DELAY_LOAD` in the middle pause cycle;
  - back-to-back spacing 5 cycles.
